// File: rtl/raiz_pkg.sv
// Shared constants for the square-root requester: state encodings and default widths.
package raiz_pkg;

    localparam logic [2:0] RQ_IDLE   = 3'd0;
    localparam logic [2:0] RQ_LAUNCH = 3'd1;
    localparam logic [2:0] RQ_WAIT   = 3'd2;
    localparam logic [2:0] RQ_ABORT  = 3'd3;
    localparam logic [2:0] RQ_OUT    = 3'd4;

    localparam int RAIZ_DATA_W  = 16;
    localparam int RAIZ_RES_W   = 8;
    localparam int RAIZ_TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = RQ_IDLE,
        ST_LAUNCH = RQ_LAUNCH,
        ST_WAIT   = RQ_WAIT,
        ST_ABORT  = RQ_ABORT,
        ST_OUT    = RQ_OUT
    } rq_state_e;

    // Counter width able to hold TC-1; never narrower than one bit.
    function automatic int ctr_width(input int tc);
        return (tc <= 2) ? 1 : $clog2(tc);
    endfunction

endpackage

// File: rtl/raiz_timeout_ctr.sv
// Saturating cycle counter for the WAIT-state watchdog; tc_o flags the terminal count TC-1.
module raiz_timeout_ctr
    import raiz_pkg::*;
#(
    parameter int TC = RAIZ_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = ctr_width(TC);
    localparam logic [CW-1:0] TC_M1 = CW'(TC - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, then count up and hold once terminal count is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CW{1'b0}};
        end else if (en_i && (cnt_q != TC_M1)) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_M1);

endmodule

// File: rtl/raiz_requester.sv
// Operand-side sequencer for the iterative square-root core: accept, launch, wait with
// watchdog, capture root (or abort), and hand the result downstream.
module raiz_requester
    import raiz_pkg::*;
#(
    parameter int DATA_W  = RAIZ_DATA_W,
    parameter int RES_W   = RAIZ_RES_W,
    parameter int TIMEOUT = RAIZ_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_root,
    output logic              out_timeout,
    output logic [DATA_W-1:0] core_A,
    output logic              core_init,
    output logic              core_rst,
    input  logic              core_done,
    input  logic [RES_W-1:0]  core_result,
    output logic              err_stray
);

    rq_state_e         state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [RES_W-1:0]  out_root_q, out_root_d;
    logic              out_timeout_q, out_timeout_d;
    logic [DATA_W-1:0] core_a_q, core_a_d;
    logic              core_init_q, core_init_d;
    logic              core_rst_q, core_rst_d;
    logic              err_stray_q, err_stray_d;
    logic              tc_s;

    raiz_timeout_ctr #(
        .TC (TIMEOUT)
    ) u_tmo (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == ST_LAUNCH),
        .en_i  (state_q == ST_WAIT),
        .tc_o  (tc_s)
    );

    // Next state and capture values; outputs are then derived from the next state so
    // they register in the same edge as the state they belong to.
    always_comb begin
        state_d       = state_q;
        core_a_d      = core_a_q;
        out_root_d    = out_root_q;
        out_timeout_d = out_timeout_q;
        err_stray_d   = err_stray_q | (core_done && (state_q != ST_WAIT));

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d  = ST_LAUNCH;
                    core_a_d = in_data;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the terminal-count cycle still counts as success.
                if (core_done) begin
                    state_d       = ST_OUT;
                    out_root_d    = core_result;
                    out_timeout_d = 1'b0;
                end else if (tc_s) begin
                    state_d = ST_ABORT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ABORT: begin
                state_d       = ST_OUT;
                out_root_d    = {RES_W{1'b0}};
                out_timeout_d = 1'b1;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_OUT);
        core_init_d = (state_d == ST_LAUNCH);
        core_rst_d  = (state_d == ST_ABORT);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_root_q    <= {RES_W{1'b0}};
            out_timeout_q <= 1'b0;
            core_a_q      <= {DATA_W{1'b0}};
            core_init_q   <= 1'b0;
            core_rst_q    <= 1'b0;
            err_stray_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_root_q    <= out_root_d;
            out_timeout_q <= out_timeout_d;
            core_a_q      <= core_a_d;
            core_init_q   <= core_init_d;
            core_rst_q    <= core_rst_d;
            err_stray_q   <= err_stray_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_root    = out_root_q;
    assign out_timeout = out_timeout_q;
    assign core_A      = core_a_q;
    assign core_init   = core_init_q;
    assign core_rst    = core_rst_q;
    assign err_stray   = err_stray_q;

endmodule

// File: tb/tb_raiz_requester.sv
// Directed bench for raiz_requester: table of radicands through a hand-driven core,
// plus timeout, reset-mid-operation and stray-done sequences.
module tb_raiz_requester;

    localparam int DW  = 16;
    localparam int RW  = 8;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] out_root;
    logic          out_timeout;
    logic [DW-1:0] core_A;
    logic          core_init;
    logic          core_rst;
    logic          core_done = 1'b0;
    logic [RW-1:0] core_result = '0;
    logic          err_stray;

    always #5 clk = ~clk;

    raiz_requester #(.DATA_W(DW), .RES_W(RW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_root(out_root),
        .out_timeout(out_timeout), .core_A(core_A), .core_init(core_init),
        .core_rst(core_rst), .core_done(core_done), .core_result(core_result),
        .err_stray(err_stray)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int init_cnt = 0;
    int init_wide = 0;
    int crst_cnt = 0;
    logic init_prev = 1'b0;

    // Pulse monitor: counts core_init / core_rst cycles and back-to-back init cycles.
    always @(negedge clk) begin
        if (core_init) init_cnt <= init_cnt + 1;
        if (core_init && init_prev) init_wide <= init_wide + 1;
        init_prev <= core_init;
        if (core_rst) crst_cnt <= crst_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural core arithmetic: floor(sqrt(v)).
    function automatic logic [RW-1:0] isqrt(input logic [DW-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 256; i++) if (i * i <= int'(v)) r = i;
        return RW'(r);
    endfunction

    task automatic wait_ready(input string name);
        int g;
        g = 0;
        while (!in_ready && g < 200) begin @(negedge clk); g++; end
        chk(name, {31'd0, in_ready}, 32'd1);
    endtask

    // One operation: done driven on the lat-th WAIT cycle, result held for `hold` cycles.
    task automatic run_op(input logic [DW-1:0] d, input int lat, input logic [RW-1:0] er,
                          input int hold);
        int i0, r0;
        logic bad_wait, bad_hold;
        wait_ready("in_ready_before_op");
        i0 = init_cnt; r0 = crst_cnt;
        bad_wait = 1'b0; bad_hold = 1'b0;
        out_ready = (hold == 0);
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        chk("launch_init", {31'd0, core_init}, 32'd1);
        chk("launch_in_ready", {31'd0, in_ready}, 32'd0);
        chk("launch_core_A", {16'd0, core_A}, {16'd0, d});
        in_valid = 1'b1; in_data = ~d;   // must be ignored while busy
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || core_A !== d || core_init !== 1'b0 ||
                core_rst !== 1'b0)
                bad_wait = 1'b1;
            if (n == lat) begin
                in_valid = 1'b0;
                core_done = 1'b1; core_result = isqrt(d);
            end
        end
        chk("wait_phase_outputs", {31'd0, bad_wait}, 32'd0);
        @(negedge clk);
        core_done = 1'b0; core_result = 8'hA5;
        chk("done_out_valid", {31'd0, out_valid}, 32'd1);
        chk("done_out_root", {24'd0, out_root}, {24'd0, er});
        chk("done_out_timeout", {31'd0, out_timeout}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_root !== er || in_ready !== 1'b0) bad_hold = 1'b1;
        end
        if (hold > 0) begin
            chk("hold_stable", {31'd0, bad_hold}, 32'd0);
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("post_accept_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_accept_out_valid", {31'd0, out_valid}, 32'd0);
        chk("one_init_per_op", init_cnt - i0, 32'd1);
        chk("no_core_rst_on_success", crst_cnt - r0, 32'd0);
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int            lat;
        logic [RW-1:0] root;
        int            hold;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n, r0;
        vecs[0] = '{16'd144,   3,  8'd12,  0};
        vecs[1] = '{16'd65535, 1,  8'd255, 0};
        vecs[2] = '{16'd0,     2,  8'd0,   0};
        vecs[3] = '{16'd1,     5,  8'd1,   0};
        vecs[4] = '{16'd2,     1,  8'd1,   0};
        vecs[5] = '{16'd100,   4,  8'd10,  20};
        vecs[6] = '{16'd50000, 64, 8'd223, 0};   // done on the terminal-count cycle
        vecs[7] = '{16'd255,   63, 8'd15,  0};

        // Reset state, then in_ready rises on the first edge after release.
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_core_init", {31'd0, core_init}, 32'd0);
        chk("rst_core_rst", {31'd0, core_rst}, 32'd0);
        chk("rst_core_A", {16'd0, core_A}, 32'd0);
        chk("rst_err_stray", {31'd0, err_stray}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);

        for (int v = 0; v < 8; v++) run_op(vecs[v].data, vecs[v].lat, vecs[v].root, vecs[v].hold);
        chk("init_single_cycle", init_wide, 32'd0);
        chk("no_stray_yet", {31'd0, err_stray}, 32'd0);

        // Timeout: core never answers; 64 WAIT cycles separate launch and abort cycles.
        wait_ready("in_ready_before_timeout");
        r0 = crst_cnt;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'd400;
        @(negedge clk);
        in_valid = 1'b0;
        chk("tmo_launch_init", {31'd0, core_init}, 32'd1);
        n = 0;
        while (!core_rst && n < 200) begin @(negedge clk); n++; end
        chk("tmo_abort_latency", n, 32'd65);
        chk("tmo_abort_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("tmo_core_rst_one_cycle", {31'd0, core_rst}, 32'd0);
        chk("tmo_out_valid", {31'd0, out_valid}, 32'd1);
        chk("tmo_out_timeout", {31'd0, out_timeout}, 32'd1);
        chk("tmo_out_root", {24'd0, out_root}, 32'd0);
        @(negedge clk);
        chk("tmo_accept_in_ready", {31'd0, in_ready}, 32'd1);
        chk("tmo_one_core_rst", crst_cnt - r0, 32'd1);

        // Reset asserted in WAIT: outputs clear immediately.
        run_op(16'd81, 2, 8'd9, 0);
        in_valid = 1'b1; in_data = 16'd200;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        r0 = crst_cnt;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_core_A", {16'd0, core_A}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_root", {24'd0, out_root}, 32'd0);
        chk("midrst_core_init", {31'd0, core_init}, 32'd0);
        chk("midrst_core_rst", {31'd0, core_rst}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_no_core_rst", crst_cnt - r0, 32'd0);

        // Stray done in IDLE: sticky error flag, no result produced.
        core_done = 1'b1; core_result = 8'h33;
        @(negedge clk);
        core_done = 1'b0;
        chk("stray_err", {31'd0, err_stray}, 32'd1);
        chk("stray_no_out_valid", {31'd0, out_valid}, 32'd0);
        chk("stray_in_ready", {31'd0, in_ready}, 32'd1);
        run_op(16'd169, 3, 8'd13, 0);
        chk("stray_sticky", {31'd0, err_stray}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/raiz_requester.md
# raiz_requester

Operand-side sequencer for the iterative square-root core. Accepts radicands on a valid/ready input stream, launches the core with a one-cycle `core_init` pulse, waits for the core's one-cycle `core_done`, captures the root, and presents it on a valid/ready output stream. It guards every launch with a cycle timeout and flags stray `core_done` pulses. It sits between the pixel/data pipeline and the root datapath-plus-control pair.

## Interface
Parameters:
- `DATA_W`, 16: radicand width.
- `RES_W`, 8: root width. Must equal `DATA_W/2`.
- `TIMEOUT`, 64: maximum cycles spent in WAIT before abort. Minimum 8.

Ports:
- `clk`  in  1: single clock; everything is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: radicand available.
- `in_ready`  out  1: block can accept a radicand.
- `in_data`  in  DATA_W: radicand.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer takes the result.
- `out_root`  out  RES_W: floor(sqrt(radicand)), or 0 on timeout.
- `out_timeout`  out  1: qualifies `out_valid`; the launch was aborted.
- `core_A`  out  DATA_W: operand held to the core, stable from launch until WAIT exits.
- `core_init`  out  1: one-cycle launch pulse.
- `core_rst`  out  1: one-cycle synchronous reset pulse to the core on abort.
- `core_done`  in  1: core completion, one cycle wide.
- `core_result`  in  RES_W: root, valid only in the `core_done` cycle.
- `err_stray`  out  1: sticky; `core_done` was seen outside WAIT. Cleared only by `rst`.

## Operation
- FSM states:
  - IDLE: `in_ready=1`.
  - LAUNCH: `core_init=1` for exactly one cycle.
  - WAIT: cycle counter runs.
  - ABORT: `core_rst=1` for exactly one cycle.
  - OUT: `out_valid=1`.
- Transitions:
  - IDLE → LAUNCH on `in_valid & in_ready`. `in_data` is captured into `core_A` on that edge.
  - LAUNCH → WAIT unconditionally. The counter clears to 0.
  - WAIT → OUT on `core_done`. `core_result` is captured into `out_root`, and `out_timeout=0`.
  - WAIT → ABORT when the counter equals `TIMEOUT-1` and `core_done=0`.
  - ABORT → OUT with `out_root=0` and `out_timeout=1`.
  - OUT → IDLE on `out_ready`.
- Simultaneous `core_done` and timeout terminal count: done wins, and the result is accepted normally.
- `core_done` in any state other than WAIT: ignored for data, sets `err_stray`, no state change.
- `in_valid` while not in IDLE: ignored. `in_ready=0` guarantees no acceptance.
- `core_A` holds its value after WAIT until the next acceptance. It is never changed mid-computation.
- Counter width is `clog2(TIMEOUT)`. It saturates and never wraps.
- Only one operation is in flight; there is no input buffering.

## Timing
- All outputs are registered.
- Reset values: `in_ready=0`, `out_valid=0`, `out_root=0`, `out_timeout=0`, `core_A=0`, `core_init=0`, `core_rst=0`, `err_stray=0`. State is IDLE.
- `in_ready` rises on the first `clk` edge after `rst` deasserts, and falls on the same edge that accepts data.
- Accept at edge T → `core_init` high for exactly the cycle T→T+1. The core samples it at edge T+1.
- `core_done` sampled at edge D → `out_valid` and `out_root` valid from edge D.
- Handshake completes at the edge where `out_valid & out_ready`. `in_ready` is 1 on that same edge's output, so back-to-back throughput is one op per (core latency + 3) cycles.
- Timeout: the abort is detected at the edge where the counter equals `TIMEOUT-1`. `core_rst` is high for the next cycle, then `out_valid` rises.
- `out_valid`, `out_root` and `out_timeout` hold stable until accepted, regardless of `out_ready` toggling.
- `rst` asserted mid-operation: immediate return to reset values. There is no `core_rst` pulse; the core shares the system reset.

## Structure
- Package `raiz_pkg`:
  - state encoding localparams `RQ_IDLE`, `RQ_LAUNCH`, `RQ_WAIT`, `RQ_ABORT`, `RQ_OUT` (3-bit);
  - `RAIZ_DATA_W=16` and `RAIZ_RES_W=8`;
  - the default `RAIZ_TIMEOUT=64`.
- One sub-module, `raiz_timeout_ctr`:
  - inputs: clear, enable, terminal-count parameter;
  - output: `tc` flag;
  - saturating.
- FSM, capture registers and the stray flag live in `raiz_requester`.

## Test plan
- Radicand 144 through a behavioural core model, `out_ready=1` → `core_init` is one cycle wide, `out_root=12`, `out_timeout=0`.
- Radicands 65535, 0, 1, 2 back-to-back → roots 255, 0, 1, 1 in order. `in_ready` low throughout each operation; exactly one `core_init` per operand.
- Core model never asserts done, `TIMEOUT=64` → `core_rst` pulses exactly 64 cycles after the LAUNCH cycle, then `out_valid=1`, `out_timeout=1`, `out_root=0`.
- Done on the terminal-count cycle → normal result with `out_timeout=0`, and no `core_rst` pulse.
- Hold `out_ready=0` for 20 cycles after done on radicand 100 → `out_root=10` stays stable. The result is accepted on the first `out_ready` cycle, then `in_ready=1` on the following cycle.
- Cases for `rst` and stray done:
  - assert `rst` mid-WAIT → all outputs return to reset values immediately;
  - a later `core_done` in IDLE → `err_stray=1` with no `out_valid`.
